// File: rtl/pipe_ctrl_n_if.sv
// Request/response bundle between the pipeline stages and the hazard controller.
interface pipe_ctrl_n_if #(
    parameter int unsigned STAGES = 6,
    parameter int unsigned PC_W   = 32,
    parameter int unsigned CNT_W  = 32
);
    logic [STAGES-1:0]      stall_req_i;
    logic [STAGES-1:0]      flush_req_i;
    logic [STAGES*PC_W-1:0] flush_pc_i;
    logic                   halt_req_i;
    logic [STAGES-1:0]      stall_o;
    logic [STAGES-1:0]      flush_o;
    logic                   redirect_o;
    logic [PC_W-1:0]        redirect_pc_o;
    logic                   halted_o;
    logic                   wdog_err_o;
    logic [CNT_W-1:0]       stall_cnt_o;

    // Pipeline side: raises requests, consumes hold/clear/redirect controls.
    modport master (
        output stall_req_i, flush_req_i, flush_pc_i, halt_req_i,
        input  stall_o, flush_o, redirect_o, redirect_pc_o,
               halted_o, wdog_err_o, stall_cnt_o
    );

    // Controller side.
    modport slave (
        input  stall_req_i, flush_req_i, flush_pc_i, halt_req_i,
        output stall_o, flush_o, redirect_o, redirect_pc_o,
               halted_o, wdog_err_o, stall_cnt_o
    );
endinterface

// File: rtl/pipe_ctrl_n.sv
// Hazard controller for an N-stage in-order pipeline: stall/flush vectors,
// deferred flush with PC redirect, debug-halt drain, stall watchdog and counter.
module pipe_ctrl_n #(
    parameter int unsigned STAGES     = 6,
    parameter int unsigned PC_W       = 32,
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned WDOG_W     = 16,
    parameter int unsigned WDOG_LIMIT = 1023
) (
    input  logic         clk,
    input  logic         rst_n,
    pipe_ctrl_n_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(STAGES);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_e;

    state_e             state_q, state_nxt;
    logic [IDX_W-1:0]   drain_q, drain_nxt;
    logic               pend_vld_q, pend_vld_nxt;
    logic [IDX_W-1:0]   pend_idx_q, pend_idx_nxt;
    logic [PC_W-1:0]    pend_pc_q, pend_pc_nxt;
    logic [WDOG_W-1:0]  wd_q, wd_nxt;
    logic               wdog_err_q, wdog_err_nxt;
    logic               halted_q;
    logic [CNT_W-1:0]   stall_cnt_q;

    logic               s_vld;
    logic [IDX_W-1:0]   s_idx;
    logic [STAGES-1:0]  req_stall_c;
    logic               live_vld;
    logic [IDX_W-1:0]   live_idx;
    logic [PC_W-1:0]    live_pc;
    logic               f_vld;
    logic [IDX_W-1:0]   f_idx;
    logic [PC_W-1:0]    f_pc;
    logic               blocked_c;
    logic [STAGES-1:0]  flush_vec_c;
    logic               issue_c;
    logic               wd_inc_c;
    logic [STAGES-1:0]  stall_c;
    logic [STAGES-1:0]  flush_c;
    logic               redirect_c;
    logic [PC_W-1:0]    redirect_pc_c;

    // Stage 0 has no requests of its own; its request bits are don't-care.
    logic unused_in;
    assign unused_in = ^{bus.stall_req_i[0], bus.flush_req_i[0], bus.flush_pc_i[PC_W-1:0]};

    // Hazard decode: oldest stall, oldest flush candidate and whether it is blocked.
    always_comb begin
        s_vld       = 1'b0;
        s_idx       = '0;
        live_vld    = 1'b0;
        live_idx    = '0;
        live_pc     = '0;
        req_stall_c = '0;
        flush_vec_c = '0;
        blocked_c   = 1'b0;
        for (int k = 1; k < int'(STAGES); k++) begin
            if (bus.stall_req_i[k]) begin
                s_vld = 1'b1;
                s_idx = IDX_W'(k);
            end
            if (bus.flush_req_i[k]) begin
                live_vld = 1'b1;
                live_idx = IDX_W'(k);
                live_pc  = bus.flush_pc_i[k*PC_W +: PC_W];
            end
        end
        for (int j = 0; j < int'(STAGES); j++) begin
            req_stall_c[j] = s_vld && (IDX_W'(j) <= s_idx);
        end
        // A live request wins a tie against the pending one.
        if (live_vld && (!pend_vld_q || (live_idx >= pend_idx_q))) begin
            f_idx = live_idx;
            f_pc  = live_pc;
        end else begin
            f_idx = pend_idx_q;
            f_pc  = pend_pc_q;
        end
        f_vld = live_vld || pend_vld_q;
        for (int k = 1; k < int'(STAGES); k++) begin
            if (bus.stall_req_i[k] && (IDX_W'(k) > f_idx)) blocked_c = 1'b1;
            if (IDX_W'(k) < f_idx) flush_vec_c[k] = 1'b1;
        end
    end

    // Next-state and control outputs.
    always_comb begin
        state_nxt     = state_q;
        drain_nxt     = drain_q;
        pend_vld_nxt  = pend_vld_q;
        pend_idx_nxt  = pend_idx_q;
        pend_pc_nxt   = pend_pc_q;
        stall_c       = '0;
        flush_c       = '0;
        redirect_c    = 1'b0;
        redirect_pc_c = '0;
        issue_c       = f_vld && !blocked_c && (state_q != HALTED);

        if (issue_c) begin
            flush_c       = flush_vec_c;
            redirect_c    = 1'b1;
            redirect_pc_c = f_pc;
        end else begin
            stall_c = req_stall_c;
        end

        unique case (state_q)
            RUN: begin
                if (bus.halt_req_i) begin
                    state_nxt = DRAIN;
                    drain_nxt = IDX_W'(STAGES - 1);
                end
            end
            DRAIN: begin
                // Hold the PC and feed bubbles until the pipe empties.
                stall_c[0] = 1'b1;
                flush_c[1] = 1'b1;
                if (!bus.halt_req_i) begin
                    state_nxt = RUN;
                end else if (!s_vld) begin
                    drain_nxt = drain_q - IDX_W'(1);
                    if (drain_q <= IDX_W'(1)) state_nxt = HALTED;
                end
            end
            HALTED: begin
                stall_c = '1;
                flush_c = '0;
                if (!bus.halt_req_i) state_nxt = RUN;
            end
            default: state_nxt = RUN;
        endcase

        if (issue_c) begin
            pend_vld_nxt = 1'b0;
        end else if (f_vld) begin
            pend_vld_nxt = 1'b1;
            pend_idx_nxt = f_idx;
            pend_pc_nxt  = f_pc;
        end
    end

    // Watchdog counts consecutive request stalls that are not relieved by a flush.
    always_comb begin
        wd_inc_c     = (state_q == RUN) && s_vld && !issue_c;
        wd_nxt       = '0;
        wdog_err_nxt = wdog_err_q;
        if (wd_inc_c) begin
            wd_nxt = (wd_q == '1) ? wd_q : wd_q + WDOG_W'(1);
            if (32'(wd_nxt) >= WDOG_LIMIT) wdog_err_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            drain_q     <= '0;
            pend_vld_q  <= 1'b0;
            pend_idx_q  <= '0;
            pend_pc_q   <= '0;
            wd_q        <= '0;
            wdog_err_q  <= 1'b0;
            halted_q    <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_nxt;
            drain_q     <= drain_nxt;
            pend_vld_q  <= pend_vld_nxt;
            pend_idx_q  <= pend_idx_nxt;
            pend_pc_q   <= pend_pc_nxt;
            wd_q        <= wd_nxt;
            wdog_err_q  <= wdog_err_nxt;
            halted_q    <= (state_nxt == HALTED);
            if (s_vld) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    // Control vectors are forced quiet while reset is held.
    assign bus.stall_o       = rst_n ? stall_c       : '0;
    assign bus.flush_o       = rst_n ? flush_c       : '0;
    assign bus.redirect_o    = rst_n ? redirect_c    : 1'b0;
    assign bus.redirect_pc_o = rst_n ? redirect_pc_c : '0;
    assign bus.halted_o      = halted_q;
    assign bus.wdog_err_o    = wdog_err_q;
    assign bus.stall_cnt_o   = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl_n.sv
// Bench for pipe_ctrl_n: directed vector table, multi-cycle sequences and
// randomized traffic against a behavioural model.
module tb_pipe_ctrl_n;
    localparam int N     = 6;
    localparam int PW    = 32;
    localparam int LIMIT = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pipe_ctrl_n_if #(.STAGES(N), .PC_W(PW), .CNT_W(32)) bus ();

    pipe_ctrl_n #(
        .STAGES(N), .PC_W(PW), .CNT_W(32), .WDOG_W(16), .WDOG_LIMIT(LIMIT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [N-1:0] st, input logic [N-1:0] fl,
                         input logic [N*PW-1:0] pcs, input logic halt);
        bus.stall_req_i = st;
        bus.flush_req_i = fl;
        bus.flush_pc_i  = pcs;
        bus.halt_req_i  = halt;
        #1;
    endtask

    function automatic logic [N*PW-1:0] pc_fill(input logic [31:0] base);
        logic [N*PW-1:0] v;
        for (int k = 0; k < N; k++) v[k*PW +: PW] = base + 32'(k);
        return v;
    endfunction

    function automatic logic [N*PW-1:0] pc_one(input int k, input logic [31:0] pc);
        logic [N*PW-1:0] v;
        v = '0;
        v[k*PW +: PW] = pc;
        return v;
    endfunction

    task automatic chk_comb(input string tag, input logic [N-1:0] st, input logic [N-1:0] fl,
                            input logic rd, input logic [31:0] pc);
        chk({tag, ".stall"}, 64'(bus.stall_o), 64'(st));
        chk({tag, ".flush"}, 64'(bus.flush_o), 64'(fl));
        chk({tag, ".redir"}, 64'(bus.redirect_o), 64'(rd));
        chk({tag, ".pc"}, 64'(bus.redirect_pc_o), 64'(pc));
    endtask

    // ---------------- behavioural model ----------------
    localparam int M_RUN = 0, M_DRAIN = 1, M_HALT = 2;
    int          m_mode, m_left, m_pend, m_wd;
    logic [31:0] m_pend_pc, m_cnt;
    bit          m_err;
    int          e_s, e_f;
    logic [31:0] e_fpc;
    bit          e_issue;
    logic [N-1:0] e_stall, e_flush;
    logic [31:0] e_pc;

    task automatic model_reset();
        m_mode = M_RUN; m_left = 0; m_pend = -1; m_pend_pc = '0;
        m_wd = 0; m_cnt = '0; m_err = 1'b0;
    endtask

    task automatic model_eval(input logic [N-1:0] st, input logic [N-1:0] fl,
                              input logic [N*PW-1:0] pcs);
        int lf;
        logic [N-1:0] req;
        e_s = -1; lf = -1;
        for (int k = 1; k < N; k++) begin
            if (st[k]) e_s = k;
            if (fl[k]) lf = k;
        end
        if (lf >= 0 && lf >= m_pend) begin
            e_f = lf; e_fpc = pcs[lf*PW +: PW];
        end else begin
            e_f = m_pend; e_fpc = m_pend_pc;
        end
        req     = (e_s >= 1) ? N'((1 << (e_s + 1)) - 1) : '0;
        e_issue = (e_f >= 1) && (e_s <= e_f) && (m_mode != M_HALT);
        e_stall = e_issue ? '0 : req;
        e_flush = e_issue ? N'((1 << e_f) - 2) : '0;
        e_pc    = e_issue ? e_fpc : '0;
        if (m_mode == M_DRAIN) begin
            e_stall[0] = 1'b1;
            e_flush[1] = 1'b1;
        end
        if (m_mode == M_HALT) begin
            e_stall = '1;
            e_flush = '0;
        end
    endtask

    task automatic model_step(input logic halt);
        if (e_issue) m_pend = -1;
        else if (e_f >= 1) begin
            m_pend = e_f; m_pend_pc = e_fpc;
        end
        if (e_s >= 1) m_cnt = m_cnt + 32'd1;
        if (m_mode == M_RUN && e_s >= 1 && !e_issue) begin
            if (m_wd < 65535) m_wd++;
            if (m_wd >= LIMIT) m_err = 1'b1;
        end else begin
            m_wd = 0;
        end
        case (m_mode)
            M_RUN:   if (halt) begin m_mode = M_DRAIN; m_left = N - 1; end
            M_DRAIN: if (!halt) m_mode = M_RUN;
                     else if (e_s < 1) begin
                         m_left--;
                         if (m_left == 0) m_mode = M_HALT;
                     end
            default: if (!halt) m_mode = M_RUN;
        endcase
    endtask

    task automatic do_reset();
        drive('0, '0, '0, 1'b0);
        rst_n = 1'b0;
        model_reset();
        tick();
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [N-1:0] st;
        logic [N-1:0] fl;
        logic [31:0]  base;
        logic [N-1:0] e_st;
        logic [N-1:0] e_fl;
        logic         e_rd;
        logic [31:0]  e_pc;
    } vec_t;

    vec_t vt[12];

    initial begin
        vt[0]  = '{6'b010000, 6'b000000, 32'h0,     6'b011111, 6'b000000, 1'b0, 32'h0};
        vt[1]  = '{6'b000010, 6'b000000, 32'h0,     6'b000011, 6'b000000, 1'b0, 32'h0};
        vt[2]  = '{6'b000001, 6'b000000, 32'h0,     6'b000000, 6'b000000, 1'b0, 32'h0};
        vt[3]  = '{6'b100000, 6'b000000, 32'h0,     6'b111111, 6'b000000, 1'b0, 32'h0};
        vt[4]  = '{6'b000000, 6'b001000, 32'h100,   6'b000000, 6'b000110, 1'b1, 32'h103};
        vt[5]  = '{6'b000000, 6'b000010, 32'h40,    6'b000000, 6'b000000, 1'b1, 32'h41};
        vt[6]  = '{6'b000000, 6'b100000, 32'h500,   6'b000000, 6'b011110, 1'b1, 32'h505};
        vt[7]  = '{6'b000000, 6'b001010, 32'h300,   6'b000000, 6'b000110, 1'b1, 32'h303};
        vt[8]  = '{6'b000100, 6'b010000, 32'h440,   6'b000000, 6'b001110, 1'b1, 32'h444};
        vt[9]  = '{6'b001000, 6'b001000, 32'h330,   6'b000000, 6'b000110, 1'b1, 32'h333};
        vt[10] = '{6'b000000, 6'b000001, 32'hdead0, 6'b000000, 6'b000000, 1'b0, 32'h0};
        vt[11] = '{6'b000011, 6'b000100, 32'h700,   6'b000000, 6'b000010, 1'b1, 32'h702};

        rst_n = 1'b0;
        do_reset();
        chk("rst.halted", 64'(bus.halted_o), 64'd0);
        chk("rst.wdog", 64'(bus.wdog_err_o), 64'd0);
        chk("rst.cnt", 64'(bus.stall_cnt_o), 64'd0);
        chk_comb("rst", '0, '0, 1'b0, 32'h0);

        for (int i = 0; i < 12; i++) begin
            drive(vt[i].st, vt[i].fl, pc_fill(vt[i].base), 1'b0);
            chk_comb($sformatf("vec%0d", i), vt[i].e_st, vt[i].e_fl, vt[i].e_rd, vt[i].e_pc);
            tick();
        end
        chk("vec.cnt", 64'(bus.stall_cnt_o), 64'd6);

        // Stall decode with per-cycle stall counting.
        do_reset();
        drive(6'b010000, '0, '0, 1'b0);
        chk("sA.st1", 64'(bus.stall_o), 64'(6'b011111));
        tick();
        chk("sA.cnt1", 64'(bus.stall_cnt_o), 64'd1);
        drive(6'b000010, '0, '0, 1'b0);
        chk("sA.st2", 64'(bus.stall_o), 64'(6'b000011));
        tick();
        chk("sA.cnt2", 64'(bus.stall_cnt_o), 64'd2);

        // Unblocked flush from stage 3.
        do_reset();
        drive('0, 6'b001000, pc_one(3, 32'h100), 1'b0);
        chk_comb("sB", '0, 6'b000110, 1'b1, 32'h100);

        // Blocked flush deferred until the older stall drops.
        do_reset();
        drive(6'b010000, 6'b000100, pc_one(2, 32'h200), 1'b0);
        chk_comb("sC.c1", 6'b011111, '0, 1'b0, 32'h0);
        tick();
        drive(6'b010000, '0, '0, 1'b0);
        chk_comb("sC.c2", 6'b011111, '0, 1'b0, 32'h0);
        tick();
        chk_comb("sC.c3", 6'b011111, '0, 1'b0, 32'h0);
        tick();
        drive('0, '0, '0, 1'b0);
        chk_comb("sC.c4", '0, 6'b000010, 1'b1, 32'h200);
        tick();
        chk_comb("sC.c5", '0, '0, 1'b0, 32'h0);

        // Older live flush replaces a younger pending one.
        do_reset();
        drive(6'b010000, 6'b000100, pc_one(2, 32'h200), 1'b0);
        tick();
        drive(6'b010000, 6'b001000, pc_one(3, 32'h300), 1'b0);
        chk_comb("sD.c2", 6'b011111, '0, 1'b0, 32'h0);
        tick();
        drive('0, '0, '0, 1'b0);
        chk_comb("sD.c3", '0, 6'b000110, 1'b1, 32'h300);
        tick();
        chk_comb("sD.c4", '0, '0, 1'b0, 32'h0);

        // Halt drain, flush captured while halted, resume.
        do_reset();
        drive('0, '0, '0, 1'b1);
        chk("sE.run.stall", 64'(bus.stall_o), 64'd0);
        for (int i = 1; i <= 6; i++) begin
            tick();
            chk($sformatf("sE.halted%0d", i), 64'(bus.halted_o), 64'(i == 6));
            if (i < 6) begin
                chk($sformatf("sE.dst%0d", i), 64'(bus.stall_o), 64'(6'b000001));
                chk($sformatf("sE.dfl%0d", i), 64'(bus.flush_o), 64'(6'b000010));
            end
        end
        chk_comb("sE.h", 6'b111111, '0, 1'b0, 32'h0);
        drive('0, 6'b000100, pc_one(2, 32'h222), 1'b1);
        chk_comb("sE.hfl", 6'b111111, '0, 1'b0, 32'h0);
        tick();
        drive('0, '0, '0, 1'b0);
        chk_comb("sE.h2", 6'b111111, '0, 1'b0, 32'h0);
        tick();
        chk("sE.resume.halted", 64'(bus.halted_o), 64'd0);
        chk_comb("sE.resume", '0, 6'b000010, 1'b1, 32'h222);
        tick();
        chk_comb("sE.after", '0, '0, 1'b0, 32'h0);

        // Watchdog trip, stickiness and reset clear.
        do_reset();
        drive(6'b000010, '0, '0, 1'b0);
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk($sformatf("sF.wd%0d", i), 64'(bus.wdog_err_o), 64'(i == 8));
        end
        drive('0, '0, '0, 1'b0);
        tick(); tick(); tick();
        chk("sF.sticky", 64'(bus.wdog_err_o), 64'd1);
        drive(6'b100000, 6'b001000, pc_one(3, 32'h900), 1'b0);
        rst_n = 1'b0;
        #1;
        chk("sF.rst.wdog", 64'(bus.wdog_err_o), 64'd0);
        chk_comb("sF.rst", '0, '0, 1'b0, 32'h0);

        // Reset mid-drain with a pending flush discards everything.
        do_reset();
        drive(6'b100000, 6'b000100, pc_one(2, 32'h444), 1'b1);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        drive('0, '0, '0, 1'b0);
        tick();
        rst_n = 1'b1;
        #1;
        chk_comb("sG.c1", '0, '0, 1'b0, 32'h0);
        tick();
        chk_comb("sG.c2", '0, '0, 1'b0, 32'h0);
        chk("sG.halted", 64'(bus.halted_o), 64'd0);

        // Randomized traffic against the model.
        do_reset();
        begin
            logic [N-1:0]    st, fl;
            logic [N*PW-1:0] pcs;
            logic            halt;
            halt = 1'b0;
            for (int c = 0; c < 600; c++) begin
                st = N'($urandom) & N'($urandom) & N'($urandom);
                fl = N'($urandom) & N'($urandom) & N'($urandom);
                for (int k = 0; k < N; k++) pcs[k*PW +: PW] = $urandom;
                if ($urandom_range(0, 19) == 0) halt = ~halt;
                drive(st, fl, pcs, halt);
                model_eval(st, fl, pcs);
                chk_comb($sformatf("rnd%0d", c), e_stall, e_flush, e_issue, e_pc);
                model_step(halt);
                tick();
                chk($sformatf("rnd%0d.halted", c), 64'(bus.halted_o), 64'(m_mode == M_HALT));
                chk($sformatf("rnd%0d.wdog", c), 64'(bus.wdog_err_o), 64'(m_err));
                chk($sformatf("rnd%0d.cnt", c), 64'(bus.stall_cnt_o), 64'(m_cnt));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
